// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU (add/sub/and/or/xor/slt/sltu and serial sll/srl/sra).
// Latency: 1 cycle for non-shift, illegal or zero-amount shift; n+1 cycles for a shift by n.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready is seen at an edge.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   in_valid/in_ready  operand handshake (op, a, b latched on accept)
//   out_valid/out_ready result handshake (result, zero, illegal)
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_shifted, calc;
    logic [SHW-1:0]   cnt, shamt;
    logic [1:0]       sh_kind;
    logic             is_shift, is_illegal, accept, shift_last;

    assign shamt      = b[SHW-1:0];
    assign is_shift   = (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);
    assign is_illegal = (op > 4'b1001);
    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    // The shift performed while cnt==1 is the final one.
    assign shift_last = (cnt == SHW'(1));

    // Single-cycle result; shifts only take this path when shamt is zero,
    // in which case the result is simply a.
    always_comb begin
        calc = '0;
        case (op)
            4'b0000: calc = a + b;
            4'b0001: calc = a - b;
            4'b0010: calc = a & b;
            4'b0011: calc = a | b;
            4'b0100: calc = a ^ b;
            4'b0101,
            4'b0110,
            4'b0111: calc = a;
            4'b1000: calc = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1001: calc = {{(WIDTH-1){1'b0}}, (a < b)};
            default: calc = '0;
        endcase
    end

    // sh_kind holds op[1:0] of the accepted shift: 01 sll, 10 srl, 11 sra.
    always_comb begin
        acc_shifted = acc;
        case (sh_kind)
            2'b01:   acc_shifted = {acc[WIDTH-2:0], 1'b0};
            2'b10:   acc_shifted = {1'b0, acc[WIDTH-1:1]};
            default: acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (is_shift && (shamt != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sh_kind   <= '0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            acc     <= a;
                            cnt     <= shamt;
                            sh_kind <= op[1:0];
                        end else begin
                            result    <= calc;
                            zero      <= (calc == '0);
                            illegal   <= is_illegal;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_shifted;
                    cnt <= cnt - SHW'(1);
                    if (shift_last) begin
                        result    <= acc_shifted;
                        zero      <= (acc_shifted == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random bench for alu_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int sh;
        logic signed [31:0] sx;
        sh = int'(y % 32);
        sx = x;
        case (o)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return x << sh;
            4'd6: return x >> sh;
            4'd7: return sx >>> sh;
            4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9: return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Edges after the accept edge until out_valid is seen.
    function automatic int ref_lat(input logic [3:0] o, input logic [31:0] y);
        if (o >= 4'd5 && o <= 4'd7) return int'(y % 32);
        return 0;
    endfunction

    task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int k;
        logic [31:0] er;
        er = ref_res(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        chk($sformatf("%s.in_ready_idle", tag), in_ready, 1);
        @(posedge clk); #1;
        // Scramble inputs: the accepted operands must already be latched.
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 9));
        chk($sformatf("%s.in_ready_busy", tag), in_ready, 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("%s.latency", tag), k, ref_lat(o, y));
        chk($sformatf("%s.result", tag), result, er);
        chk($sformatf("%s.zero", tag), zero, (er == 0));
        chk($sformatf("%s.illegal", tag), illegal, (o > 4'd9));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("%s.out_valid_drop", tag), out_valid, 0);
        chk($sformatf("%s.in_ready_back", tag), in_ready, 1);
    endtask

    initial begin
        int seen;
        logic [3:0] ro;
        logic [31:0] ra, rb;

        // Reset state
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.zero", zero, 0);
        chk("rst.illegal", illegal, 0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1);

        // Basic arithmetic and compares
        issue("add", 4'd0, 32'd5, 32'd4);              release_out("add");
        issue("sub_wrap", 4'd1, 32'd0, 32'd1);         release_out("sub_wrap");
        issue("slt", 4'd8, 32'hFFFF_FFFF, 32'd1);      release_out("slt");
        issue("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1);     release_out("sltu");
        issue("sub_zero", 4'd1, 32'd7, 32'd7);         release_out("sub_zero");

        // Serial shifts
        issue("sra4", 4'd7, 32'h8000_0000, 32'd4);     release_out("sra4");
        issue("sra36", 4'd7, 32'h8000_0000, 32'd36);   release_out("sra36");
        issue("srl31", 4'd6, 32'h8000_0000, 32'd31);   release_out("srl31");
        issue("sll0", 4'd5, 32'h1234_5678, 32'd32);    release_out("sll0");

        // Backpressure: output held, new operands ignored
        out_ready = 1'b0;
        issue("bp", 4'd0, 32'd100, 32'd23);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 4'd0; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            chk($sformatf("bp.hold%0d.out_valid", i), out_valid, 1);
            chk($sformatf("bp.hold%0d.result", i), result, 32'd123);
            chk($sformatf("bp.hold%0d.in_ready", i), in_ready, 0);
        end
        @(negedge clk); in_valid = 1'b0;
        release_out("bp");

        // Reset mid-shift
        @(negedge clk);
        op = 4'd5; a = 32'd1; b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        chk("rstmid.out_valid", out_valid, 0);
        chk("rstmid.result", result, 0);
        chk("rstmid.zero", zero, 0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rstmid.in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rstmid.no_result", seen, 0);
        issue("post_rst_add", 4'd0, 32'd2, 32'd3);     release_out("post_rst_add");

        // Illegal op, then a legal op clears the flag
        issue("illegal", 4'b1111, 32'd9, 32'd9);       release_out("illegal");
        issue("after_ill", 4'd3, 32'd9, 32'd6);        release_out("after_ill");

        // Random ops, including illegal codes and every shift amount range
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            issue($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
            release_out($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
